// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pkg
// Purpose  : Shared types and constants for the branch resolver slice.
// Revision : 1.0  initial release
// ============================================================================
package branch_pkg;

    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [2:0] {
        COND_AL = 3'b000,
        COND_EQ = 3'b001,
        COND_NE = 3'b010,
        COND_CS = 3'b011,
        COND_CC = 3'b100,
        COND_MI = 3'b101,
        COND_PL = 3'b110,
        COND_NV = 3'b111
    } br_cond_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FLUSH = 2'd2
    } br_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond_eval
// Purpose  : Combinational condition-code evaluation against Z/C/S flags.
// Revision : 1.0  initial release
// ============================================================================
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic       i_zero,
    input  logic       i_carry,
    input  logic       i_sign,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (br_cond_e'(i_cond))
            COND_AL: o_taken = 1'b1;
            COND_EQ: o_taken = i_zero;
            COND_NE: o_taken = ~i_zero;
            COND_CS: o_taken = i_carry;
            COND_CC: o_taken = ~i_carry;
            COND_MI: o_taken = i_sign;
            COND_PL: o_taken = ~i_sign;
            COND_NV: o_taken = 1'b0;
            default: o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolver
// Purpose  : Resolves conditional branches on registered ALU flags, issues a
//            redirect to fetch and a multi-cycle flush on taken branches.
//            Optional taken/not-taken counters: define BRANCH_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module branch_resolver
    import branch_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2
)
(
    input  logic            CLK,
    input  logic            reset,
    input  logic            FLAG_ZERO,
    input  logic            FLAG_CARRY,
    input  logic            FLAG_SIGN,
    input  logic            FLAG_WR_PEND,
    input  logic            BR_VALID,
    output logic            BR_READY,
    input  logic [2:0]      BR_COND,
    input  logic [PC_W-1:0] BR_TARGET,
    output logic            BR_DONE,
    output logic            BR_TAKEN,
    output logic            REDIRECT_VALID,
    output logic [PC_W-1:0] REDIRECT_PC,
    output logic            FLUSH,
    output logic            STALL
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     TAKEN_CNT,
    output logic [15:0]     NTAKEN_CNT
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] c_FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    br_state_e              r_state;
    br_state_e              w_next_state;
    logic [2:0]             r_cond;
    logic [PC_W-1:0]        r_target;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic                   w_taken;
    logic                   w_resolve;
    logic                   r_br_done;
    logic                   r_br_taken;
    logic                   r_redirect_valid;
    logic [PC_W-1:0]        r_redirect_pc;

    branch_cond_eval u_cond_eval (
        .i_cond  (r_cond),
        .i_zero  (FLAG_ZERO),
        .i_carry (FLAG_CARRY),
        .i_sign  (FLAG_SIGN),
        .o_taken (w_taken)
    );

    // Flags are only trusted once no flag-writing ALU op is outstanding.
    assign w_resolve = (r_state == ST_EVAL) && !FLAG_WR_PEND;

    always_ff @(posedge CLK) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (BR_VALID) w_next_state = ST_EVAL;
            ST_EVAL:  if (w_resolve) w_next_state = w_taken ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: if (r_flush_cnt == '0) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        BR_READY = (r_state == ST_IDLE) && !reset;
        STALL    = (r_state == ST_EVAL);
        FLUSH    = (r_state == ST_FLUSH);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cond      <= '0;
            r_target    <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && BR_VALID) begin
                r_cond   <= BR_COND;
                r_target <= BR_TARGET;
            end
            if (w_resolve && w_taken)
                r_flush_cnt <= c_FLUSH_LOAD;
            else if (r_state == ST_FLUSH && r_flush_cnt != '0)
                r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

    // Result outputs live for exactly the cycle after the resolving edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_br_done        <= 1'b0;
            r_br_taken       <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_br_done        <= w_resolve;
            r_br_taken       <= w_resolve && w_taken;
            r_redirect_valid <= w_resolve && w_taken;
            r_redirect_pc    <= (w_resolve && w_taken) ? r_target : '0;
        end
    end

    assign BR_DONE        = r_br_done;
    assign BR_TAKEN       = r_br_taken;
    assign REDIRECT_VALID = r_redirect_valid;
    assign REDIRECT_PC    = r_redirect_pc;

`ifdef BRANCH_STATS_EN
    logic [15:0] r_taken_cnt;
    logic [15:0] r_ntaken_cnt;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_taken_cnt  <= '0;
            r_ntaken_cnt <= '0;
        end else if (r_br_done) begin
            if (r_br_taken && r_taken_cnt != 16'hFFFF)
                r_taken_cnt <= r_taken_cnt + 16'd1;
            if (!r_br_taken && r_ntaken_cnt != 16'hFFFF)
                r_ntaken_cnt <= r_ntaken_cnt + 16'd1;
        end
    end

    assign TAKEN_CNT  = r_taken_cnt;
    assign NTAKEN_CNT = r_ntaken_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolver
// Purpose  : Self-checking scoreboard bench for branch_resolver.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_resolver;

    localparam int PC_W         = 32;
    localparam int FLUSH_CYCLES = 2;

    logic            CLK = 1'b0;
    logic            reset = 1'b1;
    logic            FLAG_ZERO = 1'b0;
    logic            FLAG_CARRY = 1'b0;
    logic            FLAG_SIGN = 1'b0;
    logic            FLAG_WR_PEND = 1'b0;
    logic            BR_VALID = 1'b0;
    logic            BR_READY;
    logic [2:0]      BR_COND = 3'b000;
    logic [PC_W-1:0] BR_TARGET = '0;
    logic            BR_DONE;
    logic            BR_TAKEN;
    logic            REDIRECT_VALID;
    logic [PC_W-1:0] REDIRECT_PC;
    logic            FLUSH;
    logic            STALL;
`ifdef BRANCH_STATS_EN
    logic [15:0]     TAKEN_CNT;
    logic [15:0]     NTAKEN_CNT;
`endif

    branch_resolver #(.PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .FLAG_ZERO      (FLAG_ZERO),
        .FLAG_CARRY     (FLAG_CARRY),
        .FLAG_SIGN      (FLAG_SIGN),
        .FLAG_WR_PEND   (FLAG_WR_PEND),
        .BR_VALID       (BR_VALID),
        .BR_READY       (BR_READY),
        .BR_COND        (BR_COND),
        .BR_TARGET      (BR_TARGET),
        .BR_DONE        (BR_DONE),
        .BR_TAKEN       (BR_TAKEN),
        .REDIRECT_VALID (REDIRECT_VALID),
        .REDIRECT_PC    (REDIRECT_PC),
        .FLUSH          (FLUSH),
        .STALL          (STALL)
`ifdef BRANCH_STATS_EN
        ,
        .TAKEN_CNT      (TAKEN_CNT),
        .NTAKEN_CNT     (NTAKEN_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_exp_taken  = 0;
    int   n_exp_ntaken = 0;
    bit   mon_en = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Condition table as a per-code lookup vector.
    function automatic logic ref_taken(input logic [2:0] cond, input logic z, input logic c, input logic s);
        logic [7:0] tbl;
        tbl = {1'b0, ~s, s, ~c, c, ~z, z, 1'b1};
        return tbl[cond];
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [2:0] cond, input logic [31:0] tgt, input logic exp_taken);
        exp_t e;
        BR_VALID  = 1'b1;
        BR_COND   = cond;
        BR_TARGET = tgt;
        e.taken = exp_taken;
        e.pc    = exp_taken ? tgt : 32'h0;
        exp_q.push_back(e);
        if (exp_taken) n_exp_taken++;
        else           n_exp_ntaken++;
        step();
        BR_VALID  = 1'b0;
        BR_COND   = 3'($urandom);
        BR_TARGET = $urandom;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!BR_READY && n < 40) begin
            step();
            n++;
        end
        check_val(tag, BR_READY, 1'b1);
    endtask

    // Scoreboard: every BR_DONE pulse consumes one expected result.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (BR_DONE) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_done", 1'b1, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("br_taken", BR_TAKEN, mon_e.taken);
                    check_val("redirect_valid", REDIRECT_VALID, mon_e.taken);
                    check_val("redirect_pc", REDIRECT_PC, mon_e.pc);
                end
            end else begin
                check_val("idle_outs", {BR_TAKEN, REDIRECT_VALID, REDIRECT_PC}, '0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cnt;
        logic z, c, s, t;

        // Reset
        repeat (3) step();
        check_val("rst_ready", BR_READY, 1'b0);
        check_val("rst_outs", {BR_DONE, FLUSH, STALL, REDIRECT_VALID}, 4'b0);
        mon_en = 1'b1;
        reset  = 1'b0;
        #1;
        check_val("ready_after_rst", BR_READY, 1'b1);

        // Taken EQ branch with full flush window
        FLAG_ZERO = 1'b1;
        send(3'b001, 32'h40, 1'b1);
        check_val("a_stall", STALL, 1'b1);
        check_val("a_ready_eval", BR_READY, 1'b0);
        check_val("a_flush_eval", FLUSH, 1'b0);
        step();
        check_val("a_done", BR_DONE, 1'b1);
        check_val("a_flush1", FLUSH, 1'b1);
        check_val("a_stall_flush", STALL, 1'b0);
        check_val("a_pc", REDIRECT_PC, 32'h40);
        step();
        check_val("a_flush2", FLUSH, 1'b1);
        check_val("a_done_clr", BR_DONE, 1'b0);
        check_val("a_ready_flush", BR_READY, 1'b0);
        step();
        check_val("a_flush_end", FLUSH, 1'b0);
        check_val("a_ready_n4", BR_READY, 1'b1);

        // Not-taken NE, then back-to-back accept
        send(3'b010, 32'h80, 1'b0);
        check_val("b_stall", STALL, 1'b1);
        step();
        check_val("b_done", BR_DONE, 1'b1);
        check_val("b_taken", BR_TAKEN, 1'b0);
        check_val("b_no_flush", FLUSH, 1'b0);
        check_val("b_ready_n2", BR_READY, 1'b1);
        send(3'b000, 32'h100, 1'b1);
        check_val("b2_accepted", STALL, 1'b1);
        wait_ready("b2_timeout");

        // Pending flag write stretches EVAL; carry updated in the last pending cycle
        FLAG_CARRY   = 1'b0;
        FLAG_WR_PEND = 1'b1;
        send(3'b011, 32'h200, 1'b1);
        stall_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (STALL) stall_cnt++;
            if (i == 2) FLAG_CARRY = 1'b1;
            if (i == 3) FLAG_WR_PEND = 1'b0;
            if (i == 4) FLAG_CARRY = 1'b0;
            step();
        end
        check_val("c_stall_cycles", stall_cnt, 4);
        wait_ready("c_timeout");

        // Sweep all codes and flag combinations; flags differ before EVAL
        for (int ci = 0; ci < 8; ci++) begin
            for (int f = 0; f < 8; f++) begin
                z = f[0];
                c = f[1];
                s = f[2];
                t = ref_taken(3'(ci), z, c, s);
                FLAG_ZERO  = ~z;
                FLAG_CARRY = ~c;
                FLAG_SIGN  = ~s;
                send(3'(ci), 32'h1000 + 32'((ci * 8 + f) * 4), t);
                FLAG_ZERO  = z;
                FLAG_CARRY = c;
                FLAG_SIGN  = s;
                wait_ready("sweep_timeout");
            end
        end

        // Reset during the first FLUSH cycle
        FLAG_SIGN = 1'b1;
        send(3'b101, 32'h300, 1'b1);
        step();
        check_val("e_flush1", FLUSH, 1'b1);
        reset = 1'b1;
        n_exp_taken  = 0;
        n_exp_ntaken = 0;
        step();
        check_val("e_flush_rst", FLUSH, 1'b0);
        check_val("e_done_rst", BR_DONE, 1'b0);
        check_val("e_rv_rst", REDIRECT_VALID, 1'b0);
        check_val("e_stall_rst", STALL, 1'b0);
        check_val("e_ready_in_rst", BR_READY, 1'b0);
        reset = 1'b0;
        #1;
        check_val("e_ready_after", BR_READY, 1'b1);
        step();
        check_val("e_no_stale_rv", REDIRECT_VALID, 1'b0);
        check_val("e_flush_after", FLUSH, 1'b0);

`ifdef BRANCH_STATS_EN
        send(3'b000, 32'h500, 1'b1);
        wait_ready("s_timeout");
        send(3'b111, 32'h504, 1'b0);
        wait_ready("s_timeout");
        send(3'b000, 32'h508, 1'b1);
        wait_ready("s_timeout");
        send(3'b111, 32'h50c, 1'b0);
        wait_ready("s_timeout");
        send(3'b000, 32'h510, 1'b1);
        wait_ready("s_timeout");
        repeat (2) step();
        check_val("taken_cnt", TAKEN_CNT, 16'(n_exp_taken));
        check_val("ntaken_cnt", NTAKEN_CNT, 16'(n_exp_ntaken));
`endif

        repeat (3) step();
        check_val("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
